hack_cpu_mc: RTL and testbench

- Parametrised multi-cycle Hack CPU, the successor to the fixed 16-bit core.
- Generalises data and PC width.
- Adds handshaked instruction and data memory ports, M writes (d3), M reads with wait states, and a retire pulse.
- Sits between instruction ROM and data RAM/peripheral bus in the SoC top.

---
 rtl/hack_cpu_mc.sv | 135 +++++++++++++
 tb/tb_hack_cpu_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_mc.sv
// Multi-cycle parametrised Hack CPU with handshaked instruction and data memory ports.
// Runs FETCH -> DECODE -> [MEM_RD] -> EXEC -> [MEM_WR], with a one-cycle retire pulse per instruction.
module hack_cpu_mc #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PC_WIDTH = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0]    instruction,
    input  logic                instr_valid,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic [WIDTH-1:0]    dmem_rdata,
    input  logic                dmem_ack,
    output logic [PC_WIDTH-1:0] prog_counter,
    output logic [WIDTH-1:0]    a_reg,
    output logic [WIDTH-1:0]    d_reg,
    output logic                instr_retired
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    ir;
    logic [WIDTH-1:0]    m_val;
    logic [WIDTH-1:0]    alu_x;
    logic [WIDTH-1:0]    alu_y;
    logic [WIDTH-1:0]    alu_out;
    logic                zr;
    logic                ng;
    logic                ps;
    logic                jump;
    logic [PC_WIDTH-1:0] pc_inc;

    assign imem_addr = prog_counter;
    assign pc_inc    = prog_counter + PC_WIDTH'(1);

    always_comb begin
        alu_x = d_reg;
        alu_y = ir[12] ? m_val : a_reg;
        if (ir[11]) alu_x = '0;
        if (ir[10]) alu_x = ~alu_x;
        if (ir[9])  alu_y = '0;
        if (ir[8])  alu_y = ~alu_y;
        alu_out = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir[6])  alu_out = ~alu_out;
        zr   = (alu_out == '0);
        ng   = alu_out[WIDTH-1];
        ps   = !zr && !ng;
        jump = (ir[2] && ng) || (ir[1] && zr) || (ir[0] && ps);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= FETCH;
            ir            <= '0;
            m_val         <= '0;
            prog_counter  <= '0;
            a_reg         <= '0;
            d_reg         <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            instr_retired <= 1'b0;
        end else begin
            instr_retired <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir[WIDTH-1]) begin
                        a_reg         <= {1'b0, ir[WIDTH-2:0]};
                        prog_counter  <= pc_inc;
                        instr_retired <= 1'b1;
                        state         <= FETCH;
                    end else if (ir[12]) begin
                        dmem_addr <= a_reg;
                        dmem_we   <= 1'b0;
                        dmem_req  <= 1'b1;
                        state     <= MEM_RD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MEM_RD: begin
                    if (dmem_ack) begin
                        m_val    <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Nonblocking reads of a_reg give the pre-instruction A for jump and M address, even when d1 is set.
                    if (ir[5]) a_reg <= alu_out;
                    if (ir[4]) d_reg <= alu_out;
                    prog_counter <= jump ? a_reg[PC_WIDTH-1:0] : pc_inc;
                    if (ir[3]) begin
                        dmem_addr  <= a_reg;
                        dmem_wdata <= alu_out;
                        dmem_we    <= 1'b1;
                        dmem_req   <= 1'b1;
                        state      <= MEM_WR;
                    end else begin
                        instr_retired <= 1'b1;
                        state         <= FETCH;
                    end
                end
                MEM_WR: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        instr_retired <= 1'b1;
                        state         <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: a 16-bit core with a RAM/ack model and a 24-bit/4-bit-PC core.
// The bench drives inputs on the falling edge and samples outputs there.
module tb_hack_cpu_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] imem_addr;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [14:0] prog_counter;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        instr_retired;

    logic        rst24_n;
    logic [3:0]  imem_addr24;
    logic [23:0] instruction24;
    logic        instr_valid24;
    logic        dmem_req24;
    logic        dmem_we24;
    logic [23:0] dmem_addr24;
    logic [23:0] dmem_wdata24;
    logic [23:0] dmem_rdata24;
    logic        dmem_ack24;
    logic [3:0]  pc24;
    logic [23:0] a24;
    logic [23:0] d24;
    logic        retired24;

    logic [15:0] ram [0:255];
    int          errors = 0;
    int          checks = 0;
    int          req_cycles;
    int          we_cycles;
    int          wr_seen;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    int          cyc;
    int          pulses;

    always #5 clk = ~clk;

    hack_cpu_mc #(.WIDTH(16), .PC_WIDTH(15)) u_dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr),
        .instruction(instruction), .instr_valid(instr_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .prog_counter(prog_counter), .a_reg(a_reg), .d_reg(d_reg),
        .instr_retired(instr_retired)
    );

    hack_cpu_mc #(.WIDTH(24), .PC_WIDTH(4)) u_dut24 (
        .clk(clk), .reset_n(rst24_n), .imem_addr(imem_addr24),
        .instruction(instruction24), .instr_valid(instr_valid24),
        .dmem_req(dmem_req24), .dmem_we(dmem_we24), .dmem_addr(dmem_addr24),
        .dmem_wdata(dmem_wdata24), .dmem_rdata(dmem_rdata24), .dmem_ack(dmem_ack24),
        .prog_counter(pc24), .a_reg(a24), .d_reg(d24),
        .instr_retired(retired24)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one 16-bit instruction from FETCH until its retire pulse; the slave acks after 'delay' wait cycles.
    task automatic exec16(input logic [15:0] ins, input int delay, output int cycles);
        int waited;
        logic done;
        cycles = 0; waited = 0; done = 1'b0;
        req_cycles = 0; we_cycles = 0; wr_seen = 0;
        instruction = ins;
        instr_valid = 1'b1;
        while (cycles < 50 && !done) begin
            dmem_ack = 1'b0;
            if (dmem_req) begin
                req_cycles++;
                if (dmem_we) we_cycles++;
                if (waited >= delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = ram[dmem_addr[7:0]];
                    if (dmem_we) begin
                        wr_seen++;
                        wr_addr = dmem_addr;
                        wr_data = dmem_wdata;
                        ram[dmem_addr[7:0]] = dmem_wdata;
                    end
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (instr_retired) done = 1'b1;
        end
        instr_valid = 1'b0;
        dmem_ack    = 1'b0;
        check_eq($sformatf("retire_%04h", ins), 32'(done), 32'd1);
    endtask

    task automatic exec24(input logic [23:0] ins, output int cycles);
        logic done;
        cycles = 0; done = 1'b0;
        instruction24 = ins;
        instr_valid24 = 1'b1;
        while (cycles < 50 && !done) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (retired24) done = 1'b1;
        end
        instr_valid24 = 1'b0;
        check_eq($sformatf("retire24_%06h", ins), 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        reset_n = 1'b0; rst24_n = 1'b0;
        instruction = '0; instr_valid = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
        instruction24 = '0; instr_valid24 = 1'b0; dmem_rdata24 = '0; dmem_ack24 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pc", 32'(prog_counter), 32'd0);
        check_eq("rst_a", 32'(a_reg), 32'd0);
        check_eq("rst_d", 32'(d_reg), 32'd0);
        check_eq("rst_req", {dmem_req, dmem_we, instr_retired}, 32'd0);
        check_eq("rst_addr", 32'(dmem_addr), 32'd0);
        check_eq("rst_wdata", 32'(dmem_wdata), 32'd0);
        reset_n = 1'b1; rst24_n = 1'b1;

        // @5 ; D=A ; M=D+1
        exec16(16'h0005, 0, cyc);
        check_eq("a_inst_lat", 32'(cyc), 32'd2);
        check_eq("a_inst_a", 32'(a_reg), 32'd5);
        check_eq("a_inst_pc", 32'(prog_counter), 32'd1);
        exec16(16'hEC10, 0, cyc);
        check_eq("d_eq_a_lat", 32'(cyc), 32'd3);
        check_eq("d_eq_a_d", 32'(d_reg), 32'd5);
        exec16(16'hE7C8, 0, cyc);
        check_eq("mwr_lat", 32'(cyc), 32'd4);
        check_eq("mwr_count", 32'(wr_seen), 32'd1);
        check_eq("mwr_addr", 32'(wr_addr), 32'd5);
        check_eq("mwr_data", 32'(wr_data), 32'd6);
        check_eq("mwr_we_cycles", 32'(we_cycles), 32'd1);
        check_eq("mwr_pc", 32'(prog_counter), 32'd3);
        check_eq("mwr_imem_addr", 32'(imem_addr), 32'd3);

        // D=M with three wait states
        ram[7] = 16'h1234;
        exec16(16'h0007, 0, cyc);
        exec16(16'hFC10, 3, cyc);
        check_eq("mrd_lat", 32'(cyc), 32'd7);
        check_eq("mrd_req_cycles", 32'(req_cycles), 32'd4);
        check_eq("mrd_d", 32'(d_reg), 32'h1234);
        check_eq("mrd_no_write", 32'(wr_seen), 32'd0);
        check_eq("mrd_pc", 32'(prog_counter), 32'd5);

        // Conditional jumps
        exec16(16'hEE90, 0, cyc);
        check_eq("d_m1", 32'(d_reg), 32'hFFFF);
        exec16(16'h0014, 0, cyc);
        exec16(16'hE304, 0, cyc);
        check_eq("jlt_taken_pc", 32'(prog_counter), 32'd20);
        exec16(16'hEA90, 0, cyc);
        check_eq("d_zero", 32'(d_reg), 32'd0);
        exec16(16'hE304, 0, cyc);
        check_eq("jlt_not_taken_pc", 32'(prog_counter), 32'd22);

        // AM=M+1;JMP with A=9: read, write at old A, jump to old A
        ram[9] = 16'h00FF;
        exec16(16'h0009, 0, cyc);
        exec16(16'hFDEF, 0, cyc);
        check_eq("rmw_lat", 32'(cyc), 32'd5);
        check_eq("rmw_wr_addr", 32'(wr_addr), 32'd9);
        check_eq("rmw_wr_data", 32'(wr_data), 32'h0100);
        check_eq("rmw_pc", 32'(prog_counter), 32'd9);
        check_eq("rmw_a", 32'(a_reg), 32'h0100);

        // instr_valid low holds FETCH
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (instr_retired) pulses++;
        end
        check_eq("stall_pulses", 32'(pulses), 32'd0);
        check_eq("stall_pc", 32'(prog_counter), 32'd9);

        // Reset while a write waits for ack
        instruction = 16'hE7C8; instr_valid = 1'b1; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_req_we", {dmem_req, dmem_we}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0; instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_req", {dmem_req, dmem_we}, 32'd0);
        check_eq("midrst_pc", 32'(prog_counter), 32'd0);
        check_eq("midrst_a", 32'(a_reg), 32'd0);
        check_eq("midrst_d", 32'(d_reg), 32'd0);
        check_eq("midrst_addr", 32'(dmem_addr), 32'd0);
        check_eq("midrst_wdata", 32'(dmem_wdata), 32'd0);
        reset_n = 1'b1;
        check_eq("post_rst_imem", 32'(imem_addr), 32'd0);
        exec16(16'h0003, 0, cyc);
        check_eq("post_rst_a", 32'(a_reg), 32'd3);
        check_eq("post_rst_pc", 32'(prog_counter), 32'd1);

        // 24-bit core: ignored high bits, signed overflow into neg, 4-bit PC wrap
        exec24(24'h7FFFFF, cyc);
        check_eq("w24_a", 32'(a24), 32'h7FFFFF);
        exec24(24'hFFEC10, cyc);
        check_eq("w24_d_eq_a", 32'(d24), 32'h7FFFFF);
        exec24(24'hFFE7D0, cyc);
        check_eq("w24_d_inc", 32'(d24), 32'h800000);
        exec24(24'h00000A, cyc);
        exec24(24'hFFE304, cyc);
        check_eq("w24_jlt_pc", 32'(pc24), 32'd10);
        repeat (5) exec24(24'h000000, cyc);
        check_eq("w24_pc15", 32'(pc24), 32'd15);
        exec24(24'h000001, cyc);
        check_eq("w24_pc_wrap", 32'(pc24), 32'd0);
        check_eq("w24_no_req", 32'(dmem_req24), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
